program_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 15 +
 rtl/program_loader_if.sv | 29 ++
 rtl/byte_assembler.sv | 43 ++++
 rtl/program_loader.sv | 133 +++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StRun,
    StError
  } state_e;

  localparam logic [31:0] DefaultHaltWord = 32'hFFFF_FFFF;
  localparam int unsigned NumLanes        = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream, instruction-memory port and CPU control signals of the program loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 11
);

  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [31:0]       cpu_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_we;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, rx_data, rx_valid, cpu_pc,
    input  rx_ready, imem_addr, imem_we, imem_wdata, cpu_run, done, error, word_count
  );

  modport slave (
    input  start, rx_data, rx_valid, cpu_pc,
    output rx_ready, imem_addr, imem_we, imem_wdata, cpu_run, done, error, word_count
  );

endinterface

// File: rtl/byte_assembler.sv
// Collects four accepted bytes into a little-endian 32-bit word.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_busy
);

  localparam logic [1:0] LastLane = 2'(NumLanes - 1);

  logic [1:0]  r_cnt;
  logic [23:0] r_lanes;

  // The top lane comes straight from the input so the word is usable on its last byte.
  assign o_word       = {i_byte, r_lanes};
  assign o_word_valid = i_valid && (r_cnt == LastLane);
  assign o_busy       = (r_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_lanes <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_lanes <= '0;
    end else if (i_valid) begin
      r_cnt <= r_cnt + 2'd1;
      case (r_cnt)
        2'd0:    r_lanes[7:0]   <= i_byte;
        2'd1:    r_lanes[15:8]  <= i_byte;
        2'd2:    r_lanes[23:16] <= i_byte;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: assembles serial bytes into words, fills instruction memory, then releases the CPU.
// Optional inter-byte timeout enabled by defining PROGRAM_LOADER_TIMEOUT_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned MAX_WORDS      = 2048,
  parameter logic [31:0] HALT_WORD      = DefaultHaltWord,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic             clk,
  input logic             rst_n,
  program_loader_if.slave bus
);

  localparam logic [ADDR_W:0] MaxPtr = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] PtrOne = (ADDR_W + 1)'(1);

  state_e          r_state, w_state_d;
  logic [ADDR_W:0] r_ptr;
  logic [31:0]     r_wdata;
  logic            r_we, r_run, r_done, r_err;
  logic            w_rx_ready, w_accept, w_start, w_timeout;
  logic [31:0]     w_word;
  logic            w_word_valid, w_busy;

  assign w_rx_ready = (r_state == StRecv);
  assign w_accept   = bus.rx_valid && w_rx_ready;

  byte_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_start || w_timeout),
    .i_valid      (w_accept),
    .i_byte       (bus.rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_busy       (w_busy)
  );

  always_comb begin
    w_state_d = r_state;
    w_start   = 1'b0;
    unique case (r_state)
      StIdle, StRun, StError: begin
        if (bus.start) begin
          w_state_d = StRecv;
          w_start   = 1'b1;
        end
      end
      StRecv: begin
        if (w_word_valid) begin
          if (w_word == HALT_WORD) begin
            w_state_d = StRun;
          end else if (r_ptr == MaxPtr) begin
            w_state_d = StError;
          end else begin
            w_state_d = StWrite;
          end
        end else if (w_timeout) begin
          w_state_d = StError;
        end
      end
      StWrite: w_state_d = StRecv;
      default: w_state_d = StIdle;
    endcase
  end

  // Registered outputs are derived from the next state so they align with the state they flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_we    <= (w_state_d == StWrite);
      r_run   <= (w_state_d == StRun);
      r_done  <= (w_state_d == StRun) && (r_state != StRun);
      r_err   <= (w_state_d == StError);
      if (w_state_d == StWrite) begin
        r_wdata <= w_word;
      end
      if (w_start) begin
        r_ptr <= '0;
      end else if (r_state == StWrite) begin
        r_ptr <= r_ptr + PtrOne;
      end
    end
  end

`ifdef PROGRAM_LOADER_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [ToW-1:0] r_to_cnt;

  assign w_timeout = (r_state == StRecv) && w_busy && !w_accept &&
                     (r_to_cnt == ToW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state != StRecv) || !w_busy || w_accept) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + ToW'(1);
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  logic w_unused_busy;

  assign w_timeout     = 1'b0;
  assign w_unused_busy = w_busy;
`endif

  logic [31-ADDR_W:0] w_unused_pc;
  assign w_unused_pc = bus.cpu_pc[31:ADDR_W];

  assign bus.rx_ready   = w_rx_ready;
  assign bus.imem_addr  = (r_state == StRun) ? bus.cpu_pc[ADDR_W-1:0] : r_ptr[ADDR_W-1:0];
  assign bus.imem_we    = r_we;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_run    = r_run;
  assign bus.done       = r_done;
  assign bus.error      = r_err;
  assign bus.word_count = r_ptr;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: per-cycle transaction model plus directed literal checks.
module tb_program_loader;

  localparam int unsigned AW   = 11;
  localparam int unsigned MAXW = 4;
  localparam int unsigned TO   = 16;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(AW)) bus ();

  program_loader #(
    .ADDR_W         (AW),
    .MAX_WORDS      (MAXW),
    .HALT_WORD      (HALT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_load, m_run, m_err;
  bit          m_wr_now, m_wr_next, m_done_now, m_done_next;
  int          m_nb, m_ptr, m_last_acc;
  logic [31:0] m_word, m_wdata;
  int          cyc = 0;
  int          done_seen = 0;
  logic [AW-1:0] wl_addr[$];
  logic [31:0]   wl_data[$];

  always @(negedge clk) begin
    logic          exp_ready;
    logic [AW-1:0] exp_addr;
    cyc++;
    if (!rst_n) begin
      m_load = 0; m_run = 0; m_err = 0; m_nb = 0; m_ptr = 0;
      m_wr_next = 0; m_done_next = 0; m_wdata = '0;
    end
    m_wr_now    = m_wr_next;
    m_wr_next   = 0;
    m_done_now  = m_done_next;
    m_done_next = 0;

    exp_ready = m_load && !m_wr_now;
    exp_addr  = m_run ? bus.cpu_pc[AW-1:0] : AW'(m_ptr);
    chk("rx_ready", bus.rx_ready, exp_ready);
    chk("imem_we", bus.imem_we, m_wr_now);
    chk("imem_addr", bus.imem_addr, exp_addr);
    chk("cpu_run", bus.cpu_run, m_run);
    chk("done", bus.done, m_done_now);
    chk("error", bus.error, m_err);
    chk("word_count", bus.word_count, m_ptr);
    if (m_wr_now || !rst_n) chk("imem_wdata", bus.imem_wdata, m_wdata);
    if (bus.imem_we === 1'b1) begin
      chk("rdy_in_write", bus.rx_ready, 1'b0);
      wl_addr.push_back(bus.imem_addr);
      wl_data.push_back(bus.imem_wdata);
    end
    if (bus.done === 1'b1) done_seen++;

    if (rst_n) begin
      if (m_wr_now) m_ptr++;
      if (bus.start && !m_load) begin
        m_load = 1; m_run = 0; m_err = 0; m_ptr = 0; m_nb = 0;
      end else if (m_load && !m_wr_now && bus.rx_valid) begin
        m_word[8*m_nb +: 8] = bus.rx_data;
        m_nb++;
        m_last_acc = cyc;
        if (m_nb == 4) begin
          m_nb = 0;
          if (m_word == HALT) begin
            m_load = 0; m_run = 1; m_done_next = 1;
          end else if (m_ptr == MAXW) begin
            m_load = 0; m_err = 1;
          end else begin
            m_wr_next = 1; m_wdata = m_word;
          end
        end
      end
`ifdef PROGRAM_LOADER_TIMEOUT_EN
      else if (m_load && !m_wr_now && m_nb != 0 && (cyc - m_last_acc) == TO) begin
        m_load = 0; m_err = 1; m_nb = 0;
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.rx_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("byte_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic chk_wr(input string name, input int idx, input logic [AW-1:0] a,
                        input logic [31:0] d);
    chk({name, "_addr"}, wl_addr[idx], a);
    chk({name, "_data"}, wl_data[idx], d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.start = 0; bus.rx_data = '0; bus.rx_valid = 0; bus.cpu_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_run", bus.cpu_run, 1'b0);
    chk("rst_error", bus.error, 1'b0);
    chk("rst_word_count", bus.word_count, 0);
    chk("rst_wdata", bus.imem_wdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Two words then halt.
    pulse_start();
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    send_word(HALT);
    idle(3);
    chk("s1_nwrites", wl_addr.size(), 2);
    chk_wr("s1_w0", 0, 0, 32'h0000_0001);
    chk_wr("s1_w1", 1, 1, 32'h0000_0002);
    chk("s1_done_count", done_seen, 1);
    chk("s1_cpu_run", bus.cpu_run, 1'b1);
    chk("s1_word_count", bus.word_count, 2);

    // CPU owns the address mux in RUN; restart reloads from address 0 back-to-back.
    bus.cpu_pc = 32'd5;
    @(negedge clk);
    chk("s2_pc_addr", bus.imem_addr, 5);
    chk("s2_pc_we", bus.imem_we, 1'b0);
    tick();
    pulse_start();
    @(negedge clk);
    chk("s2_run_drop", bus.cpu_run, 1'b0);
    tick();
    base = wl_addr.size();
    send_word(32'h0403_0201);
    send_word(32'h0807_0605);
    send_word(HALT);
    idle(3);
    chk("s2_nwrites", wl_addr.size(), base + 2);
    chk_wr("s2_w0", base, 0, 32'h0403_0201);
    chk_wr("s2_w1", base + 1, 1, 32'h0807_0605);
    chk("s2_done_count", done_seen, 2);

    // Overflow: MAXW words fit, the next non-halt word errors without writing.
    pulse_start();
    base = wl_addr.size();
    for (int i = 0; i < 5; i++) send_word(32'hA0 + i);
    idle(5);
    chk("s3_nwrites", wl_addr.size(), base + 4);
    for (int i = 0; i < 4; i++) chk_wr("s3_w", base + i, AW'(i), 32'hA0 + i);
    chk("s3_error", bus.error, 1'b1);
    chk("s3_cpu_run", bus.cpu_run, 1'b0);
    chk("s3_word_count", bus.word_count, 4);

    // Halt at full memory still runs.
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(32'hB0 + i);
    send_word(HALT);
    idle(3);
    chk("s3h_cpu_run", bus.cpu_run, 1'b1);
    chk("s3h_error", bus.error, 1'b0);
    chk("s3h_word_count", bus.word_count, 4);

    // Reset mid-word discards the partial bytes.
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(3);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    base = wl_addr.size();
    pulse_start();
    send_word(32'h4433_2211);
    send_word(HALT);
    idle(3);
    chk("s4_nwrites", wl_addr.size(), base + 1);
    chk_wr("s4_w0", base, 0, 32'h4433_2211);
    chk("s4_word_count", bus.word_count, 1);

`ifdef PROGRAM_LOADER_TIMEOUT_EN
    pulse_start();
    base = wl_addr.size();
    send_byte(8'h55);
    idle(20);
    chk("s5_error", bus.error, 1'b1);
    chk("s5_cpu_run", bus.cpu_run, 1'b0);
    chk("s5_nwrites", wl_addr.size(), base);
    chk("s5_word_count", bus.word_count, 0);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
